microwave_timer: RTL and testbench
==================================

// Module: microwave_timer
// PURPOSE
//  Cook-time counter driven by microwave_SM. Consumes set4/set30/inc30/dec and returns tmr_zr.
//  Keeps a saturating binary seconds count and a parallel two-digit BCD count for the front-panel display.
//  Pulses tmr_done when a countdown reaches zero.
//  Replaces the behavioural timer model used in SM-level benches.
// PARAMETERS
//  WIDTH          7    count width in bits; must satisfy 2**WIDTH-1 >= MAX_CNT
//  MAX_CNT        99   saturation ceiling in seconds; must be <= 99 (two BCD digits)
//  TICKS_PER_SEC  100  clk cycles per decrement; used only with TMR_PRESCALE_EN
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      reset, asynchronous, active-low
//  set4      in   1      load 4 (beep duration)
//  set30     in   1      load 30
//  inc30     in   1      add 30, saturating at MAX_CNT
//  dec       in   1      decrement request
//  tmr       out  WIDTH  current count, registered
//  tmr_zr    out  1      ~|tmr, combinational from the register
//  bcd_tens  out  4      tens digit of tmr, registered
//  bcd_ones  out  4      ones digit of tmr, registered
//  tmr_done  out  1      one-cycle pulse on a dec-driven 1->0 transition
// BEHAVIOUR
//  - Reset values: tmr=0, bcd_tens=0, bcd_ones=0, tmr_done=0, tmr_zr=1, prescaler=0.
//  - Command priority, one command per cycle, takes effect at the next posedge:
//    set4 > set30 > inc30 > dec_eff.
//  - set4: tmr=4, digits 0/4.
//  - set30: tmr=30, digits 3/0.
//  - inc30: tmr=min(tmr+30, MAX_CNT).
//    - Compute in WIDTH+1 bits; no wrap.
//    - BCD: tens+=3; if the result exceeds MAX_CNT, digits = MAX_CNT digits.
//  - dec_eff when tmr==0: tmr holds 0, no underflow, tmr_done stays 0.
//  - dec_eff when tmr>0: tmr-=1.
//    - BCD decrement: ones==0 -> ones=9, tens-=1; else ones-=1.
//    - If tmr was 1, tmr_done=1 for exactly the following cycle.
//  - Ignored inputs: lower-priority commands in the same cycle are dropped.
//    Example: set30 and dec together loads 30 only.
//  - BCD registers are updated in the same cycle as tmr and are never derived from tmr by division.
//    Invariant every cycle: tens*10+ones == tmr.
//  - Reset mid-countdown: all state clears asynchronously; tmr_zr asserts immediately.
//  - No internal FSM beyond the prescaler.
//    The command path has zero latency: a command at edge N is visible on tmr after edge N.
// CONFIGURATION
//  TMR_PRESCALE_EN defined:
//    - A counter of width $clog2(TICKS_PER_SEC) advances while dec=1 and no higher-priority command is present.
//    - dec_eff = dec & (presc==TICKS_PER_SEC-1); presc then wraps to 0.
//    - presc clears to 0 on set4/set30/inc30, when dec=0, or when tmr==0.
//    - Result: one-second real-time countdown.
//  TMR_PRESCALE_EN undefined:
//    - dec_eff = dec; one decrement per clk, as the SM benches expect.
//    - The prescaler logic is not synthesised.
// TESTING
//  1 Reset: rst_n=0 -> tmr=0, tmr_zr=1, digits 0/0, tmr_done=0.
//    Release reset, hold 3 cycles idle -> values unchanged.
//  2 set30, then dec x30 -> tmr 30..0.
//    - Digits track every cycle.
//    - tmr_done high only the cycle after tmr goes 1->0.
//    - A further dec keeps tmr=0 with no done pulse.
//  3 set30, inc30, inc30, inc30 -> 60, 90, then 99 (saturated), digits 9/9.
//    Same sequence with MAX_CNT=75 -> 75, digits 7/5.
//  4 Priority:
//    - set4+set30+inc30+dec together -> tmr=4.
//    - set30+dec -> tmr=30.
//    - inc30+dec from 10 -> tmr=40.
//  5 Mid-countdown from 17: assert rst_n=0 away from a clock edge.
//    tmr=0, tmr_zr=1 before the next posedge; no tmr_done pulse.
//  6 With TMR_PRESCALE_EN, TICKS_PER_SEC=4: set4, hold dec.
//    - tmr steps 4,3,2,1,0 every 4 cycles.
//    - Dropping dec for 1 cycle restarts the 4-cycle interval.
//    Without the macro: tmr steps every cycle.

Source files
------------

// File: rtl/microwave_timer.sv
// Cook-time counter: saturating binary seconds count with a parallel two-digit BCD count.
// Define TMR_PRESCALE_EN to divide dec by TICKS_PER_SEC for a one-second real-time countdown.
module microwave_timer #(
  parameter int WIDTH         = 7,
  parameter int MAX_CNT       = 99,
  parameter int TICKS_PER_SEC = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set4,
  input  logic             set30,
  input  logic             inc30,
  input  logic             dec,
  output logic [WIDTH-1:0] tmr,
  output logic             tmr_zr,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             tmr_done
);

  localparam logic [WIDTH:0] MAX_W   = (WIDTH+1)'(MAX_CNT);
  localparam logic [WIDTH:0] THIRTY  = (WIDTH+1)'(30);
  localparam logic [3:0]     MAX_TNS = 4'(MAX_CNT / 10);
  localparam logic [3:0]     MAX_ONS = 4'(MAX_CNT % 10);

  if (MAX_CNT > 99 || MAX_CNT < 30 || (2**WIDTH) - 1 < MAX_CNT || TICKS_PER_SEC < 1) begin : g_bad_cfg
    $error("microwave_timer: illegal parameter combination");
  end

  logic [WIDTH-1:0] tmr_q, tmr_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic             done_q, done_d;
  logic             dec_eff;
  logic [WIDTH:0]   sum;

`ifdef TMR_PRESCALE_EN
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_PER_SEC - 1);
  logic [PW-1:0] presc_q, presc_d;

  // Any gap in dec, a load, or an empty timer restarts the one-second interval.
  always_comb begin
    presc_d = '0;
    dec_eff = 1'b0;
    if (!(set4 || set30 || inc30) && dec && (tmr_q != '0)) begin
      if (presc_q == PRESC_TOP) dec_eff = 1'b1;
      else                      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end
`else
  assign dec_eff = dec;
`endif

  assign sum = {1'b0, tmr_q} + THIRTY;

  always_comb begin
    tmr_d  = tmr_q;
    tens_d = tens_q;
    ones_d = ones_q;
    done_d = 1'b0;
    if (set4) begin
      tmr_d  = WIDTH'(4);
      tens_d = 4'd0;
      ones_d = 4'd4;
    end else if (set30) begin
      tmr_d  = WIDTH'(30);
      tens_d = 4'd3;
      ones_d = 4'd0;
    end else if (inc30) begin
      if (sum > MAX_W) begin
        tmr_d  = MAX_W[WIDTH-1:0];
        tens_d = MAX_TNS;
        ones_d = MAX_ONS;
      end else begin
        tmr_d  = sum[WIDTH-1:0];
        tens_d = tens_q + 4'd3;
      end
    end else if (dec_eff && (tmr_q != '0)) begin
      tmr_d  = tmr_q - WIDTH'(1);
      done_d = (tmr_q == WIDTH'(1));
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      done_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      done_q <= done_d;
    end
  end

  assign tmr      = tmr_q;
  assign tmr_zr   = ~|tmr_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign tmr_done = done_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Scoreboard bench for microwave_timer: a default instance plus a MAX_CNT=75 instance on shared inputs.
module tb_microwave_timer;
  localparam int W   = 7;
  localparam int TPS = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic set4 = 1'b0, set30 = 1'b0, inc30 = 1'b0, dec = 1'b0;
  logic [W-1:0] tmr, tmr75;
  logic [3:0]   tens, ones, tens75, ones75;
  logic         zr, zr75, done, done75;

  always #5 clk = ~clk;

  microwave_timer #(.WIDTH(W), .MAX_CNT(99), .TICKS_PER_SEC(TPS)) u_dut (
    .clk(clk), .rst_n(rst_n), .set4(set4), .set30(set30), .inc30(inc30), .dec(dec),
    .tmr(tmr), .tmr_zr(zr), .bcd_tens(tens), .bcd_ones(ones), .tmr_done(done));

  microwave_timer #(.WIDTH(W), .MAX_CNT(75), .TICKS_PER_SEC(TPS)) u_dut75 (
    .clk(clk), .rst_n(rst_n), .set4(set4), .set30(set30), .inc30(inc30), .dec(dec),
    .tmr(tmr75), .tmr_zr(zr75), .bcd_tens(tens75), .bcd_ones(ones75), .tmr_done(done75));

  int n_vec = 0, n_bad = 0;
  logic [23:0] sbq[$];
  int m_t = 0, m_p = 0, m_d = 0, m_t75 = 0, m_p75 = 0, m_d75 = 0;

  function automatic logic [23:0] expect_vec(int t, int d, int t75);
    return {7'(t), 4'(t / 10), 4'(t % 10), 1'(d), (t == 0), 7'(t75)};
  endfunction

  function automatic logic [23:0] observed();
    return {tmr, tens, ones, done, zr, tmr75};
  endfunction

  task automatic model_step(input logic [3:0] c, input int mx, inout int t, inout int p, output int dn);
    logic eff;
    dn  = 0;
    eff = c[0];
`ifdef TMR_PRESCALE_EN
    eff = c[0] && (p == TPS - 1);
    if (c[3] || c[2] || c[1] || !c[0] || t == 0 || p == TPS - 1) p = 0;
    else p = p + 1;
`endif
    if (c[3]) t = 4;
    else if (c[2]) t = 30;
    else if (c[1]) t = (t + 30 > mx) ? mx : t + 30;
    else if (eff && t > 0) begin
      dn = (t == 1) ? 1 : 0;
      t  = t - 1;
    end
  endtask

  // Apply one command {set4,set30,inc30,dec} and queue the state expected after the next edge.
  task automatic drive(input logic [3:0] c);
    {set4, set30, inc30, dec} = c;
    model_step(c, 99, m_t, m_p, m_d);
    model_step(c, 75, m_t75, m_p75, m_d75);
    sbq.push_back(expect_vec(m_t, m_d, m_t75));
  endtask

  task automatic model_reset();
    m_t = 0; m_p = 0; m_d = 0; m_t75 = 0; m_p75 = 0; m_d75 = 0;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    #12;
    sbq.push_back(expect_vec(0, 0, 0));
    e = sbq.pop_front();
    n_vec++;
    if (observed() !== e) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", observed(), e);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_countdown();
    logic [3:0] q[$];
    logic [23:0] e;
    q.push_back(4'b0100);
    repeat (31) q.push_back(4'b0001);
    q.push_back(4'b0000);
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL countdown[%0d]: got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] q[$] = '{4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic [23:0] e;
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if ({observed(), tens75, ones75} !== {e, 4'(m_t75 / 10), 4'(m_t75 % 10)}) begin
        n_bad++;
        $display("FAIL saturate[%0d]: got %h %h%h want %h %0d", i, observed(), tens75, ones75, e, m_t75);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] q[$];
    logic [23:0] e;
    q.push_back(4'b1111);
    q.push_back(4'b0101);
    repeat (20) q.push_back(4'b0001);
    q.push_back(4'b0011);
    q.push_back(4'b0000);
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL priority[%0d]: got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    drive(4'b0100);
    @(posedge clk); #1;
    void'(sbq.pop_front());
    repeat (13) begin
      drive(4'b0001);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL async_pre: got %h want %h", observed(), e);
      end
    end
    #3 rst_n = 1'b0;
    model_reset();
    sbq.push_back(expect_vec(0, 0, 0));
    #1;
    e = sbq.pop_front();
    n_vec++;
    if (observed() !== e) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", observed(), e);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      drive(4'b0001);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL async_post[%0d]: got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_prescale();
    logic [3:0] q[$];
    logic [23:0] e;
    q.push_back(4'b1000);
    repeat (6) q.push_back(4'b0001);
    q.push_back(4'b0000);
    repeat (18) q.push_back(4'b0001);
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL prescale[%0d]: got %h want %h", i, observed(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_saturate();
    test_priority();
    test_async_reset();
    test_prescale();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
